// File: rtl/reflet_vga_bitmap_writer.sv
// Single write-port owner for the bitmap frame memory: arbitrates host pixel writes
// against a rectangle-fill engine, host first, with a stall limit that keeps the fill moving.
module reflet_vga_bitmap_writer #(
    parameter int h_size        = 640,
    parameter int v_line        = 480,
    parameter int color_depth   = 8,
    parameter int bit_reduction = 0,
    parameter int max_stall     = 3,
    localparam int HW = $clog2(h_size) - bit_reduction,
    localparam int VW = $clog2(v_line) - bit_reduction,
    localparam int CD = color_depth
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          host_write_en,
    output logic          host_ready,
    input  logic [HW-1:0] host_h,
    input  logic [VW-1:0] host_v,
    input  logic [CD-1:0] host_R,
    input  logic [CD-1:0] host_G,
    input  logic [CD-1:0] host_B,
    input  logic [CD-1:0] host_a,
    input  logic          fill_start,
    input  logic [HW-1:0] fill_h0,
    input  logic [HW-1:0] fill_h1,
    input  logic [VW-1:0] fill_v0,
    input  logic [VW-1:0] fill_v1,
    input  logic [CD-1:0] fill_R,
    input  logic [CD-1:0] fill_G,
    input  logic [CD-1:0] fill_B,
    input  logic [CD-1:0] fill_a,
    output logic          fill_busy,
    output logic          fill_done,
    output logic          write_en,
    output logic [HW-1:0] h_pixel_in,
    output logic [VW-1:0] v_pixel_in,
    output logic [CD-1:0] R_in,
    output logic [CD-1:0] G_in,
    output logic [CD-1:0] B_in,
    output logic [CD-1:0] a_in
);
    localparam int SW = $clog2(max_stall + 1);
    localparam logic [HW-1:0] H_MAX = HW'(h_size / (2 ** bit_reduction) - 1);
    localparam logic [VW-1:0] V_MAX = VW'(v_line / (2 ** bit_reduction) - 1);
    localparam logic [SW-1:0] STALL_LIMIT = SW'(max_stall);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [0:0]    state;
    logic [SW-1:0] stall_cnt;
    logic [HW-1:0] h_lo, h_hi, cur_h;
    logic [VW-1:0] v_hi, cur_v;
    logic [CD-1:0] f_R, f_G, f_B, f_a;

    logic          host_grant, fill_grant, fill_last;
    logic [HW-1:0] h_lo_c, h_hi_c;
    logic [VW-1:0] v_lo_c, v_hi_c;

    // Host handshake: a write is accepted in any cycle where host_write_en and host_ready
    // are both high. host_ready depends only on state and stall count, never on host_write_en.
    always_comb begin
        host_ready = !(state == FILL && stall_cnt == STALL_LIMIT);
        host_grant = host_write_en && host_ready;
        fill_grant = !host_grant && (state == FILL);
        fill_last  = (cur_h == h_hi) && (cur_v == v_hi);
    end

    // Normalise the corners, then clip every bound to the visible area.
    always_comb begin
        h_lo_c = (fill_h0 < fill_h1) ? fill_h0 : fill_h1;
        h_hi_c = (fill_h0 < fill_h1) ? fill_h1 : fill_h0;
        v_lo_c = (fill_v0 < fill_v1) ? fill_v0 : fill_v1;
        v_hi_c = (fill_v0 < fill_v1) ? fill_v1 : fill_v0;
        if (h_lo_c > H_MAX) h_lo_c = H_MAX;
        if (h_hi_c > H_MAX) h_hi_c = H_MAX;
        if (v_lo_c > V_MAX) v_lo_c = V_MAX;
        if (v_hi_c > V_MAX) v_hi_c = V_MAX;
    end

    assign fill_busy = (state == FILL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stall_cnt  <= '0;
            h_lo       <= '0;
            h_hi       <= '0;
            v_hi       <= '0;
            cur_h      <= '0;
            cur_v      <= '0;
            f_R        <= '0;
            f_G        <= '0;
            f_B        <= '0;
            f_a        <= '0;
            write_en   <= 1'b0;
            fill_done  <= 1'b0;
            h_pixel_in <= '0;
            v_pixel_in <= '0;
            R_in       <= '0;
            G_in       <= '0;
            B_in       <= '0;
            a_in       <= '0;
        end else begin
            write_en  <= host_grant || fill_grant;
            fill_done <= fill_grant && fill_last;

            if (host_grant) begin
                h_pixel_in <= host_h;
                v_pixel_in <= host_v;
                R_in       <= host_R;
                G_in       <= host_G;
                B_in       <= host_B;
                a_in       <= host_a;
            end else if (fill_grant) begin
                h_pixel_in <= cur_h;
                v_pixel_in <= cur_v;
                R_in       <= f_R;
                G_in       <= f_G;
                B_in       <= f_B;
                a_in       <= f_a;
            end

            case (state)
                IDLE: begin
                    if (fill_start) begin
                        h_lo      <= h_lo_c;
                        h_hi      <= h_hi_c;
                        v_hi      <= v_hi_c;
                        cur_h     <= h_lo_c;
                        cur_v     <= v_lo_c;
                        f_R       <= fill_R;
                        f_G       <= fill_G;
                        f_B       <= fill_B;
                        f_a       <= fill_a;
                        stall_cnt <= '0;
                        state     <= FILL;
                    end
                end
                default: begin
                    if (host_grant) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end else begin
                        stall_cnt <= '0;
                        if (fill_last) begin
                            state <= IDLE;
                        end else if (cur_h == h_hi) begin
                            cur_h <= h_lo;
                            cur_v <= cur_v + 1'b1;
                        end else begin
                            cur_h <= cur_h + 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reflet_vga_bitmap_writer.sv
// Directed bench for the bitmap writer: host writes, fills, corner swap, stall pattern,
// clipping, host/fill collision and reset abort, all against hand-computed expectations.
module tb_reflet_vga_bitmap_writer;
    logic       clk = 1'b0;
    logic       reset;
    logic       host_write_en;
    logic       host_ready;
    logic [9:0] host_h;
    logic [8:0] host_v;
    logic [7:0] host_R, host_G, host_B, host_a;
    logic       fill_start;
    logic [9:0] fill_h0, fill_h1;
    logic [8:0] fill_v0, fill_v1;
    logic [7:0] fill_R, fill_G, fill_B, fill_a;
    logic       fill_busy, fill_done, write_en;
    logic [9:0] h_pixel_in;
    logic [8:0] v_pixel_in;
    logic [7:0] R_in, G_in, B_in, a_in;

    int n_checks = 0;
    int n_errors = 0;
    logic [18:0] exp_q[$];

    reflet_vga_bitmap_writer dut (
        .clk(clk), .reset(reset),
        .host_write_en(host_write_en), .host_ready(host_ready),
        .host_h(host_h), .host_v(host_v),
        .host_R(host_R), .host_G(host_G), .host_B(host_B), .host_a(host_a),
        .fill_start(fill_start),
        .fill_h0(fill_h0), .fill_h1(fill_h1), .fill_v0(fill_v0), .fill_v1(fill_v1),
        .fill_R(fill_R), .fill_G(fill_G), .fill_B(fill_B), .fill_a(fill_a),
        .fill_busy(fill_busy), .fill_done(fill_done), .write_en(write_en),
        .h_pixel_in(h_pixel_in), .v_pixel_in(v_pixel_in),
        .R_in(R_in), .G_in(G_in), .B_in(B_in), .a_in(a_in)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_host(input logic [9:0] h, input logic [8:0] v);
        host_h = h; host_v = v;
        host_R = 8'd11; host_G = 8'd22; host_B = 8'd33; host_a = 8'd44;
    endtask

    task automatic set_fill(input logic [9:0] h0, input logic [9:0] h1,
                            input logic [8:0] v0, input logic [8:0] v1, input logic [7:0] c);
        fill_h0 = h0; fill_h1 = h1; fill_v0 = v0; fill_v1 = v1;
        fill_R = c; fill_G = c + 8'd1; fill_B = c + 8'd2; fill_a = c + 8'd3;
    endtask

    task automatic check_fill_write(input string tag, input logic [18:0] e,
                                    input logic [7:0] c, input logic last);
        check_val({tag, "_we"}, 32'(write_en), 32'd1);
        check_val({tag, "_hv"}, 32'({h_pixel_in, v_pixel_in}), 32'(e));
        check_val({tag, "_rgba"}, {R_in, G_in, B_in, a_in},
                  {c, c + 8'd1, c + 8'd2, c + 8'd3});
        check_val({tag, "_done"}, 32'(fill_done), 32'(last));
        check_val({tag, "_busy"}, 32'(fill_busy), 32'(!last));
    endtask

    // Start a fill and walk exp_q, one fill write per cycle with no host traffic.
    task automatic run_fill(input string tag, input logic [9:0] h0, input logic [9:0] h1,
                            input logic [8:0] v0, input logic [8:0] v1, input logic [7:0] c);
        int n;
        set_fill(h0, h1, v0, v1, c);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        check_val({tag, "_busy_start"}, 32'(fill_busy), 32'd1);
        check_val({tag, "_we_start"}, 32'(write_en), 32'd0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            logic [18:0] e;
            tick();
            e = exp_q.pop_front();
            check_fill_write(tag, e, c, i == n - 1);
        end
        tick();
        check_val({tag, "_we_after"}, 32'(write_en), 32'd0);
        check_val({tag, "_done_after"}, 32'(fill_done), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        host_write_en = 1'b0;
        fill_start = 1'b0;
        set_host('0, '0);
        set_fill('0, '0, '0, '0, '0);
        tick();
        tick();
        check_val("rst_we", 32'(write_en), 32'd0);
        check_val("rst_busy", 32'(fill_busy), 32'd0);
        check_val("rst_done", 32'(fill_done), 32'd0);
        check_val("rst_hv", 32'({h_pixel_in, v_pixel_in}), 32'd0);
        check_val("rst_rgba", {R_in, G_in, B_in, a_in}, 32'd0);
        check_val("rst_ready", 32'(host_ready), 32'd1);
        reset = 1'b0;
        tick();
        check_val("idle_we", 32'(write_en), 32'd0);

        // Single host write: visible one cycle after the grant.
        set_host(10'd5, 9'd7);
        host_write_en = 1'b1;
        check_val("host_ready", 32'(host_ready), 32'd1);
        tick();
        host_write_en = 1'b0;
        check_val("host_we", 32'(write_en), 32'd1);
        check_val("host_hv", 32'({h_pixel_in, v_pixel_in}), 32'({10'd5, 9'd7}));
        check_val("host_rgba", {R_in, G_in, B_in, a_in}, {8'd11, 8'd22, 8'd33, 8'd44});
        check_val("host_ready2", 32'(host_ready), 32'd1);
        tick();
        check_val("host_we_after", 32'(write_en), 32'd0);
        check_val("host_hold_hv", 32'({h_pixel_in, v_pixel_in}), 32'({10'd5, 9'd7}));

        // 2x2 fill, then the same rectangle with swapped corners.
        exp_q = '{{10'd1, 9'd1}, {10'd2, 9'd1}, {10'd1, 9'd2}, {10'd2, 9'd2}};
        run_fill("fill2x2", 10'd1, 10'd2, 9'd1, 9'd2, 8'hFF);
        exp_q = '{{10'd1, 9'd1}, {10'd2, 9'd1}, {10'd1, 9'd2}, {10'd2, 9'd2}};
        run_fill("swap2x2", 10'd2, 10'd1, 9'd2, 9'd1, 8'hFF);

        // Host saturating the port: 3 host grants, then 1 forced fill grant.
        set_fill(10'd0, 10'd3, 9'd0, 9'd0, 8'h40);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        set_host(10'd9, 9'd9);
        host_write_en = 1'b1;
        for (int g = 0; g < 16; g++) begin
            check_val("stall_ready", 32'(host_ready), 32'(g % 4 != 3));
            tick();
            if (g % 4 == 3) begin
                check_fill_write("stall_fill", {10'(g / 4), 9'd0}, 8'h40, g == 15);
            end else begin
                check_val("stall_host_hv", 32'({h_pixel_in, v_pixel_in}), 32'({10'd9, 9'd9}));
                check_val("stall_host_done", 32'(fill_done), 32'd0);
            end
        end
        host_write_en = 1'b0;
        check_val("stall_ready_end", 32'(host_ready), 32'd1);
        tick();

        // Clipping: far corner beyond the screen (v 1000 truncates to 488 on 9 bits).
        exp_q = '{{10'd638, 9'd479}, {10'd639, 9'd479}};
        run_fill("clip", 10'd638, 10'd1000, 9'd479, 9'd488, 8'h10);

        // Host write and fill_start together in IDLE: host first, fill next.
        set_host(10'd20, 9'd30);
        set_fill(10'd3, 10'd3, 9'd4, 9'd4, 8'h80);
        host_write_en = 1'b1;
        fill_start = 1'b1;
        tick();
        host_write_en = 1'b0;
        fill_start = 1'b0;
        check_val("coll_host_hv", 32'({h_pixel_in, v_pixel_in}), 32'({10'd20, 9'd30}));
        check_val("coll_busy", 32'(fill_busy), 32'd1);
        tick();
        check_fill_write("coll_fill", {10'd3, 9'd4}, 8'h80, 1'b1);
        tick();

        // Reset after two writes of a 3x3 fill aborts it cleanly.
        set_fill(10'd0, 10'd2, 9'd0, 9'd2, 8'h20);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        tick();
        check_fill_write("abort_w0", {10'd0, 9'd0}, 8'h20, 1'b0);
        tick();
        check_fill_write("abort_w1", {10'd1, 9'd0}, 8'h20, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("abort_we", 32'(write_en), 32'd0);
        check_val("abort_done", 32'(fill_done), 32'd0);
        check_val("abort_busy", 32'(fill_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("abort_quiet_we", 32'(write_en), 32'd0);
            check_val("abort_quiet_done", 32'(fill_done), 32'd0);
        end

        exp_q = '{{10'd5, 9'd6}};
        run_fill("single", 10'd5, 10'd5, 9'd6, 9'd6, 8'h33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reflet_vga_bitmap_writer.md
Name: reflet_VGA_bitmap_writer

Overview:
- Write-port controller for the bitmap frame memory; owns its single write port (write_en, h/v pixel, R/G/B/a).
- Arbitrates between a host pixel-write stream (valid/ready) and an internal rectangle-fill engine.
- Host has priority. A starvation counter guarantees fill progress.
- All memory-side outputs are registered.

Parameters:
- h_size, 640, horizontal resolution before reduction
- v_line, 480, vertical resolution before reduction
- color_depth, 8, bits per channel
- bit_reduction, 0, coordinate bits dropped; must match the bitmap instance
- max_stall, 3, consecutive host grants tolerated while fill is pending (>=1)

Ports:
- HW = $clog2(h_size)-bit_reduction; VW = $clog2(v_line)-bit_reduction; CD = color_depth
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- host_write_en  in  1  host write valid
- host_ready  out  1  host write accepted this cycle when high with host_write_en
- host_h / host_v  in  HW / VW  host pixel coordinate
- host_R, host_G, host_B, host_a  in  CD each  host colour
- fill_start  in  1  start fill (accepted only in IDLE)
- fill_h0, fill_h1  in  HW  rectangle corners, horizontal
- fill_v0, fill_v1  in  VW  rectangle corners, vertical
- fill_R, fill_G, fill_B, fill_a  in  CD each  fill colour
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse with the last fill write
- write_en  out  1  to bitmap
- h_pixel_in / v_pixel_in  out  HW / VW  to bitmap
- R_in, G_in, B_in, a_in  out  CD each  to bitmap

Behaviour:
- Reset (sync, high):
  - State=IDLE; stall_cnt=0.
  - write_en, fill_done, h_pixel_in, v_pixel_in, colour outputs all 0; fill_busy 0.
  - Reset mid-fill aborts the fill: no further writes, no fill_done.
- Limits: h_max = h_size/2^bit_reduction - 1; v_max = v_line/2^bit_reduction - 1.
- States:
  - IDLE: fill_start=1 latches corners and colour, then goes to FILL next cycle.
  - FILL: goes to IDLE in the cycle after the last fill pixel is granted.
- fill_busy = (state==FILL), driven from the state register.
- Fill latching:
  - lo = min(h0,h1), hi = max(h0,h1); same for v.
  - Each bound is clipped to h_max / v_max.
  - Scan starts at (h_lo, v_lo), row-major: h increments; at h_hi, h wraps to h_lo and v increments. Last pixel is (h_hi, v_hi).
  - fill_start while FILL: ignored.
- host_ready = !(state==FILL && stall_cnt==max_stall). Combinational from state/counter, not from host_write_en.
- Per-cycle grant:
  - host_write_en && host_ready: host granted. If in FILL, stall_cnt++.
  - Else if FILL: fill granted; stall_cnt=0; scan position advances.
  - Else: nothing granted.
- Latency: a grant in cycle N gives write_en=1 with that coordinate and colour in cycle N+1. No grant gives write_en=0; other outputs hold their last value.
- fill_done=1 in the same cycle as the write_en of the last fill pixel. fill_busy is already 0 in that cycle.
- fill_start in the same cycle as a host write in IDLE: the host write is granted, and the fill begins next cycle.
- A single-pixel rectangle (h0=h1, v0=v1) gives exactly one fill write plus fill_done.
- Writes per fill = (h_hi-h_lo+1)*(v_hi-v_lo+1), exact; no duplicates, no gaps.

Test Plan:
- Reset, then host write (5,7), RGBA=11,22,33,44 → next cycle write_en=1, h=5, v=7, colours match. host_ready=1 throughout; write_en=0 before and after.
- fill (1,1)-(2,2), colour FF, no host traffic → fill_busy 1 from the cycle after start. write_en sequence (1,1),(2,1),(1,2),(2,2) on 4 consecutive cycles. fill_done with (2,2); fill_busy 0 in that cycle.
- Swapped corners h0=2, h1=1, v0=2, v1=1 → identical sequence to the previous test.
- max_stall=3, fill (0,0)-(3,0), host_write_en held high → repeating pattern of 3 host writes then 1 fill write. host_ready low exactly on every 4th cycle; 4 fill writes total; fill_done after the 16th grant.
- Clipping: fill (638,479)-(1000,1000) with HW=10, VW=9 → writes exactly (638,479), (639,479), then fill_done.
- Reset asserted after 2 writes of a 3x3 fill → write_en 0 from the next cycle, no fill_done, fill_busy 0. A new fill_start is then accepted normally.
